scale_block_fetch: RTL and testbench

- Upstream feeder for the 2x2 scaling stage.
- Walks the source image in 2x2 blocks, raster order, and reads each block's four pixels from a synchronous source RAM/ROM.
- Presents the pixels in A -> B -> C -> D order (A B top row, C D bottom row) on the exact cycles the scaling stage samples them.
- Drives that stage's enable and holds its mode inputs stable for the whole run; also flags the two write-back cycles for the downstream writer.

---
 rtl/scale_block_fetch.sv | 165 ++++++++++++++++
 tb/tb_scale_block_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_block_fetch.sv
// scale_block_fetch
//   Feeds the 2x2 scaling stage. Walks the source image in 2x2 blocks, in
//   raster order. For each block it reads pixels A, B (top row) and C, D
//   (bottom row) from a synchronous source memory. Each pixel reaches
//   pixel_out on the exact slot where the scaling stage samples it.
//
//   Slot map per block (one cycle each, back-to-back):
//     0 INIT, 1 A, 2 B, 3 C, 4 D/WB1, 5 WB2
//
// Ports
//   clk          : single clock; all logic on posedge
//   rst          : synchronous, active-high reset
//   start        : one-cycle request to process one full frame
//   mode_in      : one-hot process mode, latched on an accepted start
//   trans_in     : transition flag, latched on an accepted start
//   rd_addr      : source read address; data returns one cycle later
//   rd_data      : source pixel {R,G,B}
//   pixel_out    : pixel to the scaling stage (zero outside slots 1..4)
//   scale_enable : scaling-stage enable, high for the whole frame
//   mode_out     : latched mode
//   trans_out    : latched transition flag
//   wb_valid     : high on the two write-back slots
//   busy         : frame in progress
//   done         : one-cycle pulse after the last block
//
// Optional feature
//   `define SCALE_BLOCK_CNT_EN adds output blk_cnt[15:0]. It counts
//   completed blocks, saturates at 16'hFFFF, is cleared on rst and on an
//   accepted start, and holds its value while idle.

module scale_block_fetch #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mode_in,
  input  logic              trans_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       pixel_out,
  output logic              scale_enable,
  output logic [2:0]        mode_out,
  output logic              trans_out,
  output logic              wb_valid,
  output logic              busy,
  output logic              done
`ifdef SCALE_BLOCK_CNT_EN
  ,
  output logic [15:0]       blk_cnt
`endif
);

  localparam int BX_W = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int BY_W = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;
  localparam logic [BX_W-1:0]   BX_LAST = BX_W'(IMG_W / 2 - 1);
  localparam logic [BY_W-1:0]   BY_LAST = BY_W'(IMG_H / 2 - 1);
  localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(IMG_W);
  localparam logic [2:0]        SLOT_LAST = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [2:0]      slot;
  logic [BX_W-1:0] bx;
  logic [BY_W-1:0] by;

  logic              run;
  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] base_addr;

  assign run = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      slot         <= 3'd0;
      bx           <= '0;
      by           <= '0;
      scale_enable <= 1'b0;
      mode_out     <= 3'b010;
      trans_out    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also taken on the done cycle, so a start there begins the next
          // frame after a single low cycle of scale_enable.
          if (start) begin
            state        <= RUN;
            slot         <= 3'd0;
            bx           <= '0;
            by           <= '0;
            mode_out     <= mode_in;
            trans_out    <= trans_in;
            scale_enable <= 1'b1;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (slot == SLOT_LAST) begin
            slot <= 3'd0;
            if (bx == BX_LAST) begin
              bx <= '0;
              if (by == BY_LAST) begin
                by           <= '0;
                state        <= IDLE;
                scale_enable <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
              end else begin
                by <= by + 1'b1;
              end
            end else begin
              bx <= bx + 1'b1;
            end
          end else begin
            slot <= slot + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCALE_BLOCK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= 16'd0;
    end else if (state == IDLE && start) begin
      blk_cnt <= 16'd0;
    end else if (run && slot == SLOT_LAST && blk_cnt != 16'hFFFF) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

  // Top-left pixel of the current block: (2*by)*IMG_W + 2*bx
  assign x_ext     = ADDR_W'({bx, 1'b0});
  assign y_ext     = ADDR_W'({by, 1'b0});
  assign base_addr = y_ext * ROW + x_ext;

  always_comb begin
    rd_addr = '0;
    if (run) begin
      case (slot)
        3'd0:    rd_addr = base_addr;
        3'd1:    rd_addr = base_addr + 1'b1;
        3'd2:    rd_addr = base_addr + ROW;
        3'd3:    rd_addr = base_addr + ROW + 1'b1;
        default: rd_addr = '0;
      endcase
    end
  end

  // Memory data lags the address by one cycle, so slots 1..4 carry A..D.
  assign pixel_out = (run && slot >= 3'd1 && slot <= 3'd4) ? rd_data : 24'd0;
  assign wb_valid  = run && (slot == 3'd4 || slot == 3'd5);

endmodule

// File: tb/tb_scale_block_fetch.sv
module tb_scale_block_fetch;

  localparam int W = 4;
  localparam int H = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode_in;
  logic          trans_in;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data = 24'd0;
  logic [23:0]   pixel_out;
  logic          scale_enable;
  logic [2:0]    mode_out;
  logic          trans_out;
  logic          wb_valid;
  logic          busy;
  logic          done;
`ifdef SCALE_BLOCK_CNT_EN
  logic [15:0]   blk_cnt;
`endif

  scale_block_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode_in      (mode_in),
    .trans_in     (trans_in),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pixel_out    (pixel_out),
    .scale_enable (scale_enable),
    .mode_out     (mode_out),
    .trans_out    (trans_out),
    .wb_valid     (wb_valid),
    .busy         (busy),
    .done         (done)
`ifdef SCALE_BLOCK_CNT_EN
    ,
    .blk_cnt      (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Source memory whose content equals its address.
  always @(posedge clk) rd_data <= {16'd0, rd_addr[7:0]};

  typedef struct packed {
    logic        en;
    logic        bsy;
    logic        dn;
    logic        wb;
    logic [2:0]  md;
    logic        tr;
    logic [15:0] ad;
    logic [23:0] px;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic exp_t mk(input logic en, input logic bsy, input logic dn,
                              input logic wb, input logic [2:0] md, input logic tr,
                              input int ad, input int px);
    exp_t e;
    e.en  = en;
    e.bsy = bsy;
    e.dn  = dn;
    e.wb  = wb;
    e.md  = md;
    e.tr  = tr;
    e.ad  = 16'(ad);
    e.px  = 24'(px);
    return e;
  endfunction

  // Expected per-cycle outputs of one 4x4 frame, then its done cycle.
  task automatic push_frame(input logic [2:0] m, input logic t);
    for (int yb = 0; yb < H / 2; yb++) begin
      for (int xb = 0; xb < W / 2; xb++) begin
        int a;
        a = 2 * yb * W + 2 * xb;
        sb.push_back(mk(1, 1, 0, 0, m, t, a,         0));
        sb.push_back(mk(1, 1, 0, 0, m, t, a + 1,     a));
        sb.push_back(mk(1, 1, 0, 0, m, t, a + W,     a + 1));
        sb.push_back(mk(1, 1, 0, 0, m, t, a + W + 1, a + W));
        sb.push_back(mk(1, 1, 0, 1, m, t, 0,         a + W + 1));
        sb.push_back(mk(1, 1, 0, 1, m, t, 0,         0));
      end
    end
    sb.push_back(mk(0, 0, 1, 0, m, t, 0, 0));
  endtask

  // Monitor: every cycle the DUT presents enable or done, pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (scale_enable || done) begin
        exp_t act;
        act = mk(scale_enable, busy, done, wb_valid, mode_out, trans_out,
                 int'(rd_addr), int'(pixel_out));
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got en=%b done=%b addr=%0d, required no activity",
                   scale_enable, done, rd_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL cycle_out: got en=%b bsy=%b dn=%b wb=%b md=%b tr=%b ad=%0d px=%0d, required en=%b bsy=%b dn=%b wb=%b md=%b tr=%b ad=%0d px=%0d",
                     act.en, act.bsy, act.dn, act.wb, act.md, act.tr, act.ad, act.px,
                     e.en, e.bsy, e.dn, e.wb, e.md, e.tr, e.ad, e.px);
          end else begin
            $display("vec en=%b dn=%b wb=%b ad=%0d px=%0d ok", act.en, act.dn, act.wb, act.ad, act.px);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("chk %s = %0h ok", name, act);
    end
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d pending outputs, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    start    = 1'b0;
    mode_in  = 3'b010;
    trans_in = 1'b0;
    repeat (3) tick();

    chk("rst_rd_addr",  32'(rd_addr), 32'd0);
    chk("rst_pixel",    32'(pixel_out), 32'd0);
    chk("rst_enable",   32'(scale_enable), 32'd0);
    chk("rst_mode",     32'(mode_out), 32'b010);
    chk("rst_trans",    32'(trans_out), 32'd0);
    chk("rst_wb",       32'(wb_valid), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: mode/trans change mid-run and a stray start must be ignored.
    mode_in  = 3'b001;
    trans_in = 1'b0;
    push_frame(3'b001, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    mode_in  = 3'b100;
    trans_in = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_empty(40);
    chk("f1_mode_held",  32'(mode_out), 32'b001);
    chk("f1_trans_held", 32'(trans_out), 32'd0);
    chk("f1_idle_busy",  32'(busy), 32'd0);
    chk("f1_idle_done",  32'(done), 32'd0);
`ifdef SCALE_BLOCK_CNT_EN
    chk("f1_blk_cnt", 32'(blk_cnt), 32'd4);
`endif
    repeat (3) tick();

    // Frame 2: reset on slot 2 of block 1, then a fresh full frame.
    mode_in  = 3'b010;
    trans_in = 1'b1;
    push_frame(3'b010, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    chk("midrst_enable", 32'(scale_enable), 32'd0);
    chk("midrst_addr",   32'(rd_addr), 32'd0);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_done",   32'(done), 32'd0);
    chk("midrst_mode",   32'(mode_out), 32'b010);
    rst = 1'b0;
    repeat (3) tick();
    mode_in  = 3'b100;
    trans_in = 1'b1;
    push_frame(3'b100, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_empty(40);
`ifdef SCALE_BLOCK_CNT_EN
    chk("f2_blk_cnt", 32'(blk_cnt), 32'd4);
`endif
    repeat (3) tick();

    // Frames 3+4: start held through done; next frame begins after one low cycle.
    mode_in  = 3'b010;
    trans_in = 1'b0;
    push_frame(3'b010, 1'b0);
    push_frame(3'b010, 1'b0);
    start = 1'b1;
    tick();
    k = 0;
    while (sb.size() > 25 && k < 60) begin
      tick();
      k++;
    end
    start = 1'b0;
    chk("b2b_enable_after_done", 32'(scale_enable), 32'd1);
    chk("b2b_pending", 32'(sb.size()), 32'd25);
    wait_empty(40);
`ifdef SCALE_BLOCK_CNT_EN
    chk("f4_blk_cnt", 32'(blk_cnt), 32'd4);
`endif
    chk("end_busy", 32'(busy), 32'd0);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
